// File: rtl/ofmap_result_checker.sv
// Ofmap readback engine: sweeps an address range, compares against golden data.
// Optional CHECK_TOLERANCE_EN adds tol_in and a per-lane |golden-ofmap|<=tol test.
module ofmap_result_checker #(
  parameter int MAC_COL        = 16,
  parameter int OFMAP_BITWIDTH = 32,
  parameter int OFMAP_ADDR_BIT = 10,
  parameter int RD_LATENCY     = 1,
  parameter int ERR_CNT_BIT    = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start_in,
  input  logic [OFMAP_ADDR_BIT-1:0]         base_addr_in,
  input  logic [OFMAP_ADDR_BIT:0]           num_words_in,
`ifdef CHECK_TOLERANCE_EN
  input  logic [OFMAP_BITWIDTH-2:0]         tol_in,
`endif
  output logic [OFMAP_ADDR_BIT-1:0]         test_output_addr_out,
  output logic                              test_check_out,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] test_output_in,
  output logic [OFMAP_ADDR_BIT-1:0]         golden_addr_out,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] golden_data_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              pass_out,
  output logic [ERR_CNT_BIT-1:0]            error_count_out,
  output logic [OFMAP_ADDR_BIT-1:0]         first_err_addr_out,
  output logic [MAC_COL-1:0]                lane_err_mask_out
);

  localparam int W   = OFMAP_BITWIDTH;
  localparam int A   = OFMAP_ADDR_BIT;
  localparam int L   = RD_LATENCY;
  localparam int DCW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_n;
  logic [A-1:0]         addr_q;
  logic [A:0]           rem_q;
  logic [DCW-1:0]       dcnt_q;
  logic                 done_q;
  logic [L-1:0]         vld_q;
  logic [A-1:0]         adr_q [L];
  logic [ERR_CNT_BIT-1:0] err_q;
  logic [A-1:0]         first_q;
  logic [MAC_COL-1:0]   mask_q;
  logic [MAC_COL-1:0]   mism;
  logic                 go;
  logic                 zero;
  logic                 last;
  logic                 drain_end;
  logic                 cmp_v;
  logic [A-1:0]         cmp_a;

  assign go        = (state_q == S_IDLE || state_q == S_DONE) && start_in;
  assign zero      = num_words_in == '0;
  assign last      = state_q == S_ISSUE && rem_q == (A+1)'(1);
  assign drain_end = state_q == S_DRAIN && dcnt_q == '0;

  always_comb begin
    state_n = state_q;
    unique case (1'b1)
      go && zero:  state_n = S_DONE;
      go && !zero: state_n = S_ISSUE;
      last:        state_n = S_DRAIN;
      drain_end:   state_n = S_DONE;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      rem_q  <= '0;
      dcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (go && zero) || drain_end;
      if (go) begin
        addr_q <= base_addr_in;
        rem_q  <= num_words_in;
      end else if (state_q == S_ISSUE) begin
        rem_q <= rem_q - 1'b1;
        if (!last) addr_q <= addr_q + 1'b1;
      end
      if (last) dcnt_q <= DCW'(L - 1);
      else if (state_q == S_DRAIN && dcnt_q != '0)
        dcnt_q <= dcnt_q - 1'b1;
    end
  end

`ifdef CHECK_TOLERANCE_EN
  logic [W-2:0] tol_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   tol_q <= '0;
    else if (go) tol_q <= tol_in;
  end
`endif

  // address/valid delay line aligned with the read ports
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) adr_q[i] <= '0;
    end else begin
      vld_q[0] <= state_q == S_ISSUE;
      adr_q[0] <= addr_q;
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  assign cmp_v = vld_q[L-1];
  assign cmp_a = adr_q[L-1];

  for (genvar i = 0; i < MAC_COL; i++) begin : g_lane
    logic [W-1:0] g;
    logic [W-1:0] o;
    assign g = golden_data_in[W*i +: W];
    assign o = test_output_in[W*i +: W];
`ifdef CHECK_TOLERANCE_EN
    logic signed [W:0] diff;
    logic [W:0]        mag;
    assign diff    = $signed({g[W-1], g}) - $signed({o[W-1], o});
    assign mag     = diff[W] ? $unsigned(-diff) : $unsigned(diff);
    assign mism[i] = mag > {2'b00, tol_q};
`else
    assign mism[i] = g != o;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q   <= '0;
      first_q <= '0;
      mask_q  <= '0;
    end else if (go) begin
      err_q   <= '0;
      first_q <= '0;
      mask_q  <= '0;
    end else if (cmp_v && |mism) begin
      if (err_q != '1) err_q <= err_q + 1'b1;
      if (err_q == '0) first_q <= cmp_a;
      mask_q <= mask_q | mism;
    end
  end

  assign test_output_addr_out = addr_q;
  assign golden_addr_out      = addr_q;
  assign test_check_out       = state_q == S_ISSUE;
  assign busy_out             = state_q == S_ISSUE || state_q == S_DRAIN;
  assign done_out             = done_q;
  assign pass_out             = state_q == S_DONE && err_q == '0;
  assign error_count_out      = err_q;
  assign first_err_addr_out   = first_q;
  assign lane_err_mask_out    = mask_q;

endmodule

// File: tb/tb_ofmap_result_checker.sv
// Directed bench: two checker instances (latency 1 / latency 3 + 4-bit count).
// Table of sweeps plus reset-abort, ignored-start and tolerance sequences.
module tb_ofmap_result_checker;

  localparam int MC = 16;
  localparam int W  = 32;
  localparam int A  = 10;
  localparam int WW = MC * W;

  typedef struct {
    int base;
    int num;
    int pat;
    int done_a;
    int done_b;
    int err_a;
    int err_b;
    int first;
    int mask;
    int pass;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [A-1:0] base = '0;
  logic [A:0] num = '0;
`ifdef CHECK_TOLERANCE_EN
  logic [W-2:0] tol = '0;
`endif

  logic [WW-1:0] gold_mem [1024];
  logic [WW-1:0] ofm_mem [1024];

  logic [A-1:0] a_addr, a_gaddr, a_first;
  logic a_chk, a_busy, a_done, a_pass;
  logic [15:0] a_err, a_mask;
  logic [WW-1:0] a_ofm, a_gold;

  logic [A-1:0] b_addr, b_gaddr, b_first;
  logic b_chk, b_busy, b_done, b_pass;
  logic [3:0] b_err;
  logic [15:0] b_mask;
  logic [WW-1:0] b_ofm, b_gold;

  logic [A-1:0] pa, pb0, pb1, pb2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ofmap_result_checker #(
    .MAC_COL(MC), .OFMAP_BITWIDTH(W), .OFMAP_ADDR_BIT(A),
    .RD_LATENCY(1), .ERR_CNT_BIT(16)
  ) ua (
    .clk(clk), .rstn(rstn), .start_in(start),
    .base_addr_in(base), .num_words_in(num),
`ifdef CHECK_TOLERANCE_EN
    .tol_in(tol),
`endif
    .test_output_addr_out(a_addr), .test_check_out(a_chk),
    .test_output_in(a_ofm), .golden_addr_out(a_gaddr),
    .golden_data_in(a_gold), .busy_out(a_busy), .done_out(a_done),
    .pass_out(a_pass), .error_count_out(a_err),
    .first_err_addr_out(a_first), .lane_err_mask_out(a_mask)
  );

  ofmap_result_checker #(
    .MAC_COL(MC), .OFMAP_BITWIDTH(W), .OFMAP_ADDR_BIT(A),
    .RD_LATENCY(3), .ERR_CNT_BIT(4)
  ) ub (
    .clk(clk), .rstn(rstn), .start_in(start),
    .base_addr_in(base), .num_words_in(num),
`ifdef CHECK_TOLERANCE_EN
    .tol_in(tol),
`endif
    .test_output_addr_out(b_addr), .test_check_out(b_chk),
    .test_output_in(b_ofm), .golden_addr_out(b_gaddr),
    .golden_data_in(b_gold), .busy_out(b_busy), .done_out(b_done),
    .pass_out(b_pass), .error_count_out(b_err),
    .first_err_addr_out(b_first), .lane_err_mask_out(b_mask)
  );

  // memory models: 1-cycle and 3-cycle read latency
  always @(posedge clk) begin
    pa  <= a_addr;
    pb0 <= b_addr;
    pb1 <= pb0;
    pb2 <= pb1;
  end

  assign a_ofm  = ofm_mem[pa];
  assign a_gold = gold_mem[pa];
  assign b_ofm  = ofm_mem[pb2];
  assign b_gold = gold_mem[pb2];

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // corrupt lane l of word w by adding d
  task automatic bump(input int w, input int l, input int d);
    logic [W-1:0] v;
    v = ofm_mem[w][W*l +: W];
    ofm_mem[w][W*l +: W] = v + W'(d);
  endtask

  task automatic set_pat(input int p);
    for (int w = 0; w < 1024; w++) ofm_mem[w] = gold_mem[w];
    case (p)
      1: begin
        bump(100, 3, 1);
        bump(500, 0, 1);
        bump(500, 15, 1);
      end
      2: for (int w = 0; w < 784; w++) bump(w, 5, 1);
      3: bump(2, 7, 1);
      4: bump(1023, 15, 1);
      5: begin
        bump(3, 0, 2);
        bump(4, 1, -2);
        bump(7, 2, -3);
      end
      default: ;
    endcase
  endtask

  task automatic run_sweep(input string tag, input vec_t v, input int ign);
    int ka, kb, bad_a, bad_b, da, db, nda, ndb;
    logic [A-1:0] ea;
    ka = 0; kb = 0; bad_a = 0; bad_b = 0;
    da = -1; db = -1; nda = 0; ndb = 0;
    set_pat(v.pat);
    @(negedge clk);
    base  = A'(v.base);
    num   = (A+1)'(v.num);
    start = 1'b1;
    for (int cyc = 1; cyc <= v.num + 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == ign) begin
        start = 1'b1;
        base  = 10'd7;
        num   = 11'd3;
      end
      if (a_chk) begin
        ea = A'(v.base + ka);
        if (a_addr !== ea || a_gaddr !== ea) bad_a++;
        ka++;
      end
      if (b_chk) begin
        ea = A'(v.base + kb);
        if (b_addr !== ea || b_gaddr !== ea) bad_b++;
        kb++;
      end
      if (a_done) begin
        nda++;
        if (da < 0) da = cyc;
      end
      if (b_done) begin
        ndb++;
        if (db < 0) db = cyc;
      end
    end
    chk({tag, " done_cyc_a"}, 96'(da), 96'(v.done_a));
    chk({tag, " done_cyc_b"}, 96'(db), 96'(v.done_b));
    chk({tag, " done_pulses"}, {48'(nda), 48'(ndb)}, {48'd1, 48'd1});
    chk({tag, " issues_a"}, 96'(ka), 96'(v.num));
    chk({tag, " issues_b"}, 96'(kb), 96'(v.num));
    chk({tag, " addr_seq"}, {48'(bad_a), 48'(bad_b)}, 96'd0);
    chk({tag, " err_a"}, 96'(a_err), 96'(v.err_a));
    chk({tag, " err_b"}, 96'(b_err), 96'(v.err_b));
    chk({tag, " first"}, {48'(a_first), 48'(b_first)},
        {48'(v.first), 48'(v.first)});
    chk({tag, " mask"}, {48'(a_mask), 48'(b_mask)},
        {48'(v.mask), 48'(v.mask)});
    chk({tag, " pass"}, {94'(a_pass), b_pass, a_busy | b_busy},
        {94'(v.pass), v.pass[0], 1'b0});
  endtask

  function automatic logic [95:0] outs_a();
    return 96'({a_chk, a_addr, a_gaddr, a_busy, a_done, a_pass,
                a_err, a_first, a_mask});
  endfunction

  function automatic logic [95:0] outs_b();
    return 96'({b_chk, b_addr, b_gaddr, b_busy, b_done, b_pass,
                b_err, b_first, b_mask});
  endfunction

  vec_t vecs [8];

  initial begin
    int nd;
    for (int w = 0; w < 1024; w++)
      for (int l = 0; l < MC; l++)
        gold_mem[w][W*l +: W] = W'(w * 16 + l - 5000);

    vecs[0] = '{0,    784,  0, 786,  788,  0,   0,  0,    0,      1};
    vecs[1] = '{0,    784,  1, 786,  788,  2,   2,  100,  'h8009, 0};
    vecs[2] = '{0,    784,  2, 786,  788,  784, 15, 0,    'h0020, 0};
    vecs[3] = '{1020, 8,    0, 10,   12,   0,   0,  0,    0,      1};
    vecs[4] = '{1020, 8,    3, 10,   12,   1,   1,  2,    'h0080, 0};
    vecs[5] = '{1023, 1,    4, 3,    5,    1,   1,  1023, 'h8000, 0};
    vecs[6] = '{0,    0,    1, 1,    1,    0,   0,  0,    0,      1};
    vecs[7] = '{5,    1025, 0, 1027, 1029, 0,   0,  0,    0,      1};

    set_pat(0);
    repeat (2) @(negedge clk);
    chk("reset_outs_a", outs_a(), 96'd0);
    chk("reset_outs_b", outs_b(), 96'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_sweep($sformatf("v%0d", i), vecs[i], -1);

    run_sweep("ign_start", vecs[0], 5);

    // reset in the middle of a sweep
    set_pat(1);
    @(negedge clk);
    base = '0;
    num = 11'd784;
    start = 1'b1;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_outs_a", outs_a(), 96'd0);
    chk("abort_outs_b", outs_b(), 96'd0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_done || b_done) nd++;
    end
    rstn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (a_done || b_done || a_chk || b_chk) nd++;
    end
    chk("abort_no_done", 96'(nd), 96'd0);

    run_sweep("after_abort", vecs[1], -1);

`ifdef CHECK_TOLERANCE_EN
    tol = 31'd2;
    run_sweep("tol", '{0, 16, 5, 18, 20, 1, 1, 7, 'h0004, 0}, -1);
    tol = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
